// File: rtl/sparce_pkg.sv
// rtl/sparce_pkg.sv - shared types and helpers for the SPARCE skip sequencer
package sparce_pkg;

    localparam int SKIP_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_WAIT,
        ST_SKIP
    } state_t;

    // insns is held at full width so any SKIP_W fits
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        and_op;
        logic [31:0] insns;
    } skip_desc_t;

    // Redirect lands on the instruction after the skipped run; wraps mod 2^32
    function automatic logic [31:0] skip_target(input logic [31:0] pc, input logic [31:0] insns);
        return pc + ((insns + 32'd1) << 2);
    endfunction

endpackage

// File: rtl/sparce_skip_ctrl_if.sv
// rtl/sparce_skip_ctrl_if.sv - redirect handshake from the skip sequencer to fetch
interface sparce_skip_ctrl_if;
    logic        skip_valid;
    logic        skip_ready;
    logic [31:0] skip_pc;

    modport master (output skip_valid, output skip_pc, input skip_ready);
    modport slave  (input skip_valid, input skip_pc, output skip_ready);
endinterface

// File: rtl/sparce_scoreboard.sv
// rtl/sparce_scoreboard.sv - in-flight writer bits for x1..x31 with writeback bypass
module sparce_scoreboard (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       iss_en_i,
    input  logic [4:0] iss_rd_i,
    input  logic       wb_en_i,
    input  logic [4:0] wb_rd_i,
    input  logic       flush_i,
    input  logic [4:0] src1_i,
    input  logic [4:0] src2_i,
    output logic       pend1_o,
    output logic       pend2_o
);

    logic [31:1] pend_q;
    logic [31:1] pend_d;
    logic [31:0] pend_vec;

    // A same-cycle issue to the register being written back keeps it pending
    always_comb begin
        pend_d = '0;
        for (int i = 1; i < 32; i++) begin
            pend_d[i] = (iss_en_i && iss_rd_i == 5'(i)) ||
                        (pend_q[i] && !(wb_en_i && wb_rd_i == 5'(i)));
        end
        if (flush_i) pend_d = '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) pend_q <= '0;
        else       pend_q <= pend_d;
    end

    assign pend_vec = {pend_q, 1'b0};
    assign pend1_o  = pend_vec[src1_i] && !(wb_en_i && wb_rd_i == src1_i);
    assign pend2_o  = pend_vec[src2_i] && !(wb_en_i && wb_rd_i == src2_i);

endmodule

// File: rtl/sparce_skip_ctrl.sv
// rtl/sparce_skip_ctrl.sv - turns a SASA hit into a committed skip redirect
// Optional WAIT timeout enabled by defining SPARCE_SKIP_TIMEOUT_EN.
module sparce_skip_ctrl
    import sparce_pkg::*;
#(
    parameter int SKIP_W         = SKIP_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              sasa_hit,
    input  logic [31:0]       sasa_pc,
    input  logic [4:0]        sasa_rs1,
    input  logic [4:0]        sasa_rs2,
    input  logic              sasa_and,
    input  logic [SKIP_W-1:0] sasa_insns,
    input  logic              iss_en,
    input  logic [4:0]        iss_rd,
    input  logic              wb_en,
    input  logic [4:0]        wb_rd,
    input  logic              rs1_sparsity,
    input  logic              rs2_sparsity,
    output logic [4:0]        sprf_rs1,
    output logic [4:0]        sprf_rs2,
    input  logic              abort,
    input  logic              flush,
    sparce_skip_ctrl_if.master skip,
    output logic              busy
);

    state_t      state_q;
    skip_desc_t  desc_q;
    logic        skip_valid_q;
    logic        busy_q;
    logic [31:0] skip_pc_q;
    logic        pend1;
    logic        pend2;
    logic        cond;
    logic        kill;

`ifdef SPARCE_SKIP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q;
`endif

    sparce_scoreboard u_sb (
        .CLK      (CLK),
        .nRST     (nRST),
        .iss_en_i (iss_en),
        .iss_rd_i (iss_rd),
        .wb_en_i  (wb_en),
        .wb_rd_i  (wb_rd),
        .flush_i  (flush),
        .src1_i   (desc_q.rs1),
        .src2_i   (desc_q.rs2),
        .pend1_o  (pend1),
        .pend2_o  (pend2)
    );

    assign kill = abort | flush;
    assign cond = desc_q.and_op ? (rs1_sparsity & rs2_sparsity)
                                : (rs1_sparsity | rs2_sparsity);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= ST_IDLE;
            desc_q       <= '0;
            skip_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            skip_pc_q    <= '0;
`ifdef SPARCE_SKIP_TIMEOUT_EN
            wait_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!kill && sasa_hit && sasa_insns != '0) begin
                        desc_q  <= '{pc: sasa_pc, rs1: sasa_rs1, rs2: sasa_rs2,
                                     and_op: sasa_and, insns: 32'(sasa_insns)};
                        state_q <= ST_CHECK;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CHECK, ST_WAIT: begin
                    if (kill) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (pend1 || pend2) begin
`ifdef SPARCE_SKIP_TIMEOUT_EN
                        if (state_q == ST_CHECK) begin
                            state_q    <= ST_WAIT;
                            wait_cnt_q <= '0;
                        end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            wait_cnt_q <= wait_cnt_q + 1'b1;
                        end
`else
                        state_q <= ST_WAIT;
`endif
                    end else if (cond) begin
                        state_q      <= ST_SKIP;
                        skip_valid_q <= 1'b1;
                        skip_pc_q    <= skip_target(desc_q.pc, desc_q.insns);
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_SKIP: begin
                    if (kill || skip.skip_ready) begin
                        state_q      <= ST_IDLE;
                        skip_valid_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    skip_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    assign sprf_rs1        = (state_q == ST_IDLE) ? 5'd0 : desc_q.rs1;
    assign sprf_rs2        = (state_q == ST_IDLE) ? 5'd0 : desc_q.rs2;
    assign skip.skip_valid = skip_valid_q;
    assign skip.skip_pc    = skip_pc_q;
    assign busy            = busy_q;

endmodule

// File: tb/tb_sparce_skip_ctrl.sv
// tb/tb_sparce_skip_ctrl.sv - scoreboard bench for sparce_skip_ctrl
module tb_sparce_skip_ctrl;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        sasa_hit;
    logic [31:0] sasa_pc;
    logic [4:0]  sasa_rs1, sasa_rs2;
    logic        sasa_and;
    logic [4:0]  sasa_insns;
    logic        iss_en, wb_en;
    logic [4:0]  iss_rd, wb_rd;
    logic        rs1_sparsity, rs2_sparsity;
    logic [4:0]  sprf_rs1, sprf_rs2;
    logic        abort, flush, busy;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    sparce_skip_ctrl_if skip_if ();

    sparce_skip_ctrl #(.SKIP_W(5), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .sasa_hit(sasa_hit), .sasa_pc(sasa_pc), .sasa_rs1(sasa_rs1), .sasa_rs2(sasa_rs2),
        .sasa_and(sasa_and), .sasa_insns(sasa_insns),
        .iss_en(iss_en), .iss_rd(iss_rd), .wb_en(wb_en), .wb_rd(wb_rd),
        .rs1_sparsity(rs1_sparsity), .rs2_sparsity(rs2_sparsity),
        .sprf_rs1(sprf_rs1), .sprf_rs2(sprf_rs2),
        .abort(abort), .flush(flush), .skip(skip_if.master), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Redirect monitor: every accepted handshake must match the oldest expectation
    always @(negedge CLK) begin
        if (nRST && skip_if.skip_valid && skip_if.skip_ready && !abort && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL redirect_unexpected got pc=%h required none", skip_if.skip_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (skip_if.skip_pc !== e) begin
                    errors++;
                    $display("FAIL redirect_pc got %h required %h", skip_if.skip_pc, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    task automatic do_hit(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                          input logic a, input logic [4:0] n);
        sasa_hit = 1'b1; sasa_pc = pc; sasa_rs1 = r1; sasa_rs2 = r2;
        sasa_and = a; sasa_insns = n;
        tick();
        sasa_hit = 1'b0;
    endtask

    task automatic handshake();
        skip_if.skip_ready = 1'b1;
        tick();
        skip_if.skip_ready = 1'b0;
    endtask

    initial begin
        nRST = 1'b0; sasa_hit = 0; sasa_pc = 0; sasa_rs1 = 0; sasa_rs2 = 0; sasa_and = 0;
        sasa_insns = 0; iss_en = 0; iss_rd = 0; wb_en = 0; wb_rd = 0;
        rs1_sparsity = 0; rs2_sparsity = 0; abort = 0; flush = 0;
        skip_if.skip_ready = 1'b0;
        tick(); tick();
        chk("reset_busy", 32'(busy), 0);
        chk("reset_valid", 32'(skip_if.skip_valid), 0);
        chk("reset_pc", skip_if.skip_pc, 0);
        chk("reset_sprf", {22'd0, sprf_rs1, sprf_rs2}, 0);
        nRST = 1'b1;
        tick();

        // Zero-insns hit is ignored
        do_hit(32'h50, 5'd1, 5'd2, 1'b1, 5'd0);
        chk("zero_insns_busy", 32'(busy), 0);

        // No pending sources: minimum latency 2
        rs1_sparsity = 1; rs2_sparsity = 1;
        do_hit(32'h100, 5'd5, 5'd6, 1'b1, 5'd3);
        chk("t1_check_busy", 32'(busy), 1);
        chk("t1_check_valid", 32'(skip_if.skip_valid), 0);
        chk("t1_sprf", {22'd0, sprf_rs1, sprf_rs2}, {22'd0, 5'd5, 5'd6});
        exp_q.push_back(32'h110);
        tick();
        chk("t1_valid_n2", 32'(skip_if.skip_valid), 1);
        chk("t1_pc", skip_if.skip_pc, 32'h110);
        handshake();
        chk("t1_valid_drop", 32'(skip_if.skip_valid), 0);
        chk("t1_busy_drop", 32'(busy), 0);
        chk("t1_sprf_idle", {22'd0, sprf_rs1, sprf_rs2}, 0);

        // Back-to-back hit in the cycle after the handshake, with pc wrap
        do_hit(32'hFFFF_FFF8, 5'd5, 5'd6, 1'b1, 5'd1);
        exp_q.push_back(32'h0000_0000);
        tick();
        chk("wrap_valid", 32'(skip_if.skip_valid), 1);
        chk("wrap_pc", skip_if.skip_pc, 32'h0);
        handshake();

        // Pending source resolved by writeback in cycle M
        iss_en = 1; iss_rd = 5'd5;
        tick();
        iss_en = 0;
        do_hit(32'h200, 5'd5, 5'd6, 1'b1, 5'd2);
        tick(); tick(); tick();
        chk("t2_wait_valid", 32'(skip_if.skip_valid), 0);
        chk("t2_wait_busy", 32'(busy), 1);
        wb_en = 1; wb_rd = 5'd5;
        exp_q.push_back(32'h20C);
        tick();
        wb_en = 0;
        chk("t2_skip_m1", 32'(skip_if.skip_valid), 1);
        handshake();

        // Not sparse, OR mode: straight back to IDLE, ready held high throughout
        rs1_sparsity = 0; rs2_sparsity = 0;
        skip_if.skip_ready = 1'b1;
        do_hit(32'h280, 5'd8, 5'd9, 1'b0, 5'd1);
        chk("t3_check_busy", 32'(busy), 1);
        tick();
        chk("t3_busy_drop", 32'(busy), 0);
        tick(); tick();
        chk("t3_no_valid", 32'(skip_if.skip_valid), 0);
        skip_if.skip_ready = 1'b0;

        // OR mode with only one sparse source skips
        rs1_sparsity = 0; rs2_sparsity = 1;
        do_hit(32'h2A0, 5'd8, 5'd9, 1'b0, 5'd2);
        exp_q.push_back(32'h2AC);
        tick();
        chk("or_valid", 32'(skip_if.skip_valid), 1);
        handshake();

        // Issue and writeback of x7 in the same cycle keeps x7 pending
        rs1_sparsity = 1; rs2_sparsity = 1;
        iss_en = 1; iss_rd = 5'd7; wb_en = 1; wb_rd = 5'd7;
        tick();
        iss_en = 0; wb_en = 0;
        do_hit(32'h300, 5'd7, 5'd7, 1'b0, 5'd1);
        tick(); tick();
        chk("t4_waits", {31'd0, skip_if.skip_valid} | {30'd0, busy, 1'b0}, 32'd2);
        wb_en = 1; wb_rd = 5'd7;
        exp_q.push_back(32'h308);
        tick();
        wb_en = 0;
        chk("t4_skip", 32'(skip_if.skip_valid), 1);
        handshake();

        // Abort beats a same-cycle ready: no redirect counted
        do_hit(32'h400, 5'd1, 5'd2, 1'b1, 5'd4);
        tick();
        chk("t5_valid", 32'(skip_if.skip_valid), 1);
        abort = 1; skip_if.skip_ready = 1'b1;
        tick();
        abort = 0; skip_if.skip_ready = 1'b0;
        chk("t5_abort_valid", 32'(skip_if.skip_valid), 0);
        chk("t5_abort_busy", 32'(busy), 0);

        // Flush in WAIT clears the scoreboard
        iss_en = 1; iss_rd = 5'd10;
        tick();
        iss_rd = 5'd11;
        tick();
        iss_en = 0;
        do_hit(32'h500, 5'd10, 5'd11, 1'b1, 5'd1);
        tick();
        chk("t6_wait_busy", 32'(busy), 1);
        flush = 1;
        tick();
        flush = 0;
        chk("t6_flush_busy", 32'(busy), 0);
        do_hit(32'h600, 5'd10, 5'd11, 1'b1, 5'd1);
        exp_q.push_back(32'h608);
        tick();
        chk("t6_cleared", 32'(skip_if.skip_valid), 1);
        handshake();

        // Source never written back
        iss_en = 1; iss_rd = 5'd12;
        tick();
        iss_en = 0;
        do_hit(32'h700, 5'd12, 5'd12, 1'b1, 5'd1);
`ifdef SPARCE_SKIP_TIMEOUT_EN
        for (int i = 0; i < 16; i++) tick();
        chk("to_last_wait", 32'(busy), 1);
        tick();
        chk("to_idle", 32'(busy), 0);
`else
        for (int i = 0; i < 100; i++) tick();
        chk("noto_still_wait", 32'(busy), 1);
        chk("noto_no_valid", 32'(skip_if.skip_valid), 0);
`endif
        flush = 1;
        tick();
        flush = 0;

        // Asynchronous reset mid-operation
        do_hit(32'h800, 5'd3, 5'd4, 1'b1, 5'd2);
        #2 nRST = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_sprf", {22'd0, sprf_rs1, sprf_rs2}, 0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        tick(); tick();
        chk("async_after_valid", 32'(skip_if.skip_valid), 0);

        chk("redirects_outstanding", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
